// File: rtl/fifo_pkt_pkg.sv
// fifo_pkt_pkg: shared state encoding and header layout for the FIFO packet scheduler
package fifo_pkt_pkg;
    typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, GAP} state_t;
    localparam int HDR_LEN = 4;
    localparam logic [1:0] HDR_SYNC   = 2'd0;
    localparam logic [1:0] HDR_SEQ    = 2'd1;
    localparam logic [1:0] HDR_LEN_HI = 2'd2;
    localparam logic [1:0] HDR_LEN_LO = 2'd3;
endpackage

// File: rtl/pkt_skid_buf.sv
// pkt_skid_buf: 2-entry byte buffer between FIFO read data and the TX handshake
//   sys_clk, rst_n : clock, async active-low reset
//   push, din      : write din at the tail
//   pop            : drop the head entry
//   dout           : head entry
//   cnt            : entries held (0..2); push and pop may coincide
module pkt_skid_buf
    import fifo_pkt_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic [1:0]        cnt
);
    logic [DATA_W-1:0] d0, d1;
    assign dout = d0;
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            d0  <= '0;
            d1  <= '0;
            cnt <= '0;
        end else begin
            if (pop) d0 <= d1;
            // write slot is the occupancy left after this cycle's pop
            if (push && (cnt - 2'(pop)) == 2'd0) d0 <= din;
            if (push && (cnt - 2'(pop)) == 2'd1) d1 <= din;
            cnt <= cnt + 2'(push) - 2'(pop);
        end
    end
endmodule

// File: rtl/fifo_pkt_scheduler.sv
// fifo_pkt_scheduler: frames async-FIFO read data into SYNC/SEQ/LEN headed TX packets
//   sys_clk, rst_n        : FIFO read clock, async active-low reset
//   enable, frame_end     : launch permission, end-of-frame flush request pulse
//   fifo_level/empty      : read-side FIFO status
//   fifo_rd_en            : FIFO read request; fifo_dout/fifo_valid return a cycle later
//   tx_data/valid/last    : TX byte stream, tx_ready handshake
//   pkt_busy, pkt_cnt     : packet in progress, completed packet count
//   underrun_err          : sticky mid-payload starvation flag
module fifo_pkt_scheduler
    import fifo_pkt_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int LEVEL_W   = 15,
    parameter int PKT_LEN   = 1024,
    parameter int GAP_CYC   = 16,
    parameter int STALL_MAX = 4096,
    parameter logic [DATA_W-1:0] SYNC_BYTE = 8'hA5
) (
    input  logic               sys_clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               frame_end,
    input  logic [LEVEL_W-1:0] fifo_level,
    input  logic               fifo_empty,
    output logic               fifo_rd_en,
    input  logic [DATA_W-1:0]  fifo_dout,
    input  logic               fifo_valid,
    output logic [DATA_W-1:0]  tx_data,
    output logic               tx_valid,
    output logic               tx_last,
    input  logic               tx_ready,
    output logic               pkt_busy,
    output logic [15:0]        pkt_cnt,
    output logic               underrun_err
);
    localparam int GAP_W = $clog2(GAP_CYC + 1);
    localparam int STALL_W = $clog2(STALL_MAX + 1);
    localparam logic [15:0] PKT_LEN16 = 16'(PKT_LEN);
    state_t state;
    logic [1:0] hdr_idx, skid_cnt;
    logic [15:0] len, rd_remain, tx_remain, level16;
    logic [7:0] seq;
    logic [GAP_W-1:0] gap_cnt;
    logic [STALL_W-1:0] stall_cnt;
    logic frame_pend, inflight, skid_push, skid_pop, stall_tick, launch, tail_ok;
    logic [DATA_W-1:0] skid_dout, hdr_byte;
    assign level16 = 16'(fifo_level);
    assign tail_ok = frame_pend && level16 != 16'd0;
    assign launch = state == IDLE && enable && (level16 >= PKT_LEN16 || tail_ok);
    // at most two bytes either buffered or still returning from the FIFO
    assign fifo_rd_en = state == PAYLOAD && rd_remain != 16'd0 && !fifo_empty
                        && (skid_cnt + 2'(inflight)) < 2'd2;
    assign hdr_byte = hdr_idx == HDR_SYNC   ? SYNC_BYTE :
                      hdr_idx == HDR_SEQ    ? DATA_W'(seq) :
                      hdr_idx == HDR_LEN_HI ? DATA_W'(len[15:8]) : DATA_W'(len[7:0]);
    assign tx_valid = state == HDR || (state == PAYLOAD && skid_cnt != 2'd0);
    assign tx_data = state == HDR ? hdr_byte : tx_valid ? skid_dout : '0;
    assign tx_last = state == PAYLOAD && skid_cnt != 2'd0 && tx_remain == 16'd1;
    assign pkt_busy = state != IDLE;
    // stale returns after a reset or outside a packet are dropped
    assign skid_push = fifo_valid && state == PAYLOAD;
    assign skid_pop = state == PAYLOAD && tx_valid && tx_ready;
    assign stall_tick = state == PAYLOAD && rd_remain != 16'd0 && fifo_empty;
    pkt_skid_buf #(.DATA_W(DATA_W)) u_skid (
        .sys_clk(sys_clk),
        .rst_n(rst_n),
        .push(skid_push),
        .din(fifo_dout),
        .pop(skid_pop),
        .dout(skid_dout),
        .cnt(skid_cnt)
    );
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            hdr_idx      <= '0;
            len          <= '0;
            rd_remain    <= '0;
            tx_remain    <= '0;
            seq          <= '0;
            gap_cnt      <= '0;
            stall_cnt    <= '0;
            frame_pend   <= 1'b0;
            inflight     <= 1'b0;
            pkt_cnt      <= '0;
            underrun_err <= 1'b0;
        end else begin
            inflight <= fifo_rd_en;
            // a pulse coinciding with consumption stays pending for the next launch
            frame_pend <= frame_end || (frame_pend && !(state == IDLE && enable && level16 < PKT_LEN16));
            stall_cnt <= (fifo_rd_en || state != PAYLOAD) ? '0 :
                         (stall_tick && stall_cnt != STALL_W'(STALL_MAX)) ? stall_cnt + 1'b1 : stall_cnt;
            underrun_err <= underrun_err || (stall_tick && stall_cnt == STALL_W'(STALL_MAX - 1));
            if (fifo_rd_en) rd_remain <= rd_remain - 16'd1;
            if (skid_pop) tx_remain <= tx_remain - 16'd1;
            case (state)
                IDLE: begin
                    hdr_idx <= '0;
                    gap_cnt <= '0;
                    if (launch) begin
                        len       <= level16 >= PKT_LEN16 ? PKT_LEN16 : level16;
                        rd_remain <= level16 >= PKT_LEN16 ? PKT_LEN16 : level16;
                        tx_remain <= level16 >= PKT_LEN16 ? PKT_LEN16 : level16;
                        state     <= HDR;
                    end
                end
                HDR: if (tx_ready) begin
                    hdr_idx <= hdr_idx + 2'd1;
                    if (hdr_idx == 2'(HDR_LEN - 1)) state <= PAYLOAD;
                end
                PAYLOAD: if (tx_last && tx_ready) begin
                    seq     <= seq + 8'd1;
                    pkt_cnt <= pkt_cnt + 16'd1;
                    state   <= GAP;
                end
                GAP: begin
                    gap_cnt <= gap_cnt + 1'b1;
                    if (gap_cnt == GAP_W'(GAP_CYC - 1)) state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_pkt_scheduler.sv
// tb_fifo_pkt_scheduler: FIFO model + packet scoreboard bench for fifo_pkt_scheduler
module tb_fifo_pkt_scheduler;
    localparam int PKT_LEN = 8;
    localparam int GAP_CYC = 16;
    localparam int STALL_MAX = 64;
    typedef struct {logic [7:0] d; logic last; logic pay;} exp_t;
    logic sys_clk = 1'b0;
    logic rst_n, enable, frame_end, tx_ready;
    logic fifo_empty = 1'b1, fifo_valid = 1'b0;
    logic [14:0] fifo_level = '0;
    logic [7:0] fifo_dout = '0;
    logic fifo_rd_en, tx_valid, tx_last, pkt_busy, underrun_err;
    logic [7:0] tx_data;
    logic [15:0] pkt_cnt;
    exp_t exp_q[$];
    exp_t mon_e;
    logic [7:0] fifo_q[$], pay_q[$], cap_q[$];
    logic capl_q[$];
    int tests = 0, fails = 0, rd_total = 0, pay_popped = 0, m_pkt = 0, gap_left = 0, mseq = 0;
    logic force_empty = 1'b0, rand_rdy = 1'b0;
    logic [7:0] t1e [12] = '{8'hA5, 8'h00, 8'h00, 8'h08, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
    logic [7:0] t2e [7] = '{8'hA5, 8'h01, 8'h00, 8'h03, 8'h20, 8'h21, 8'h22};

    fifo_pkt_scheduler #(
        .DATA_W(8), .LEVEL_W(15), .PKT_LEN(PKT_LEN), .GAP_CYC(GAP_CYC),
        .STALL_MAX(STALL_MAX), .SYNC_BYTE(8'hA5)
    ) dut (
        .sys_clk(sys_clk), .rst_n(rst_n), .enable(enable), .frame_end(frame_end),
        .fifo_level(fifo_level), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
        .fifo_dout(fifo_dout), .fifo_valid(fifo_valid), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_last(tx_last), .tx_ready(tx_ready),
        .pkt_busy(pkt_busy), .pkt_cnt(pkt_cnt), .underrun_err(underrun_err)
    );

    initial forever #5 sys_clk = ~sys_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    function automatic int launch_len(input int level, input bit pend);
        return level >= PKT_LEN ? PKT_LEN : (pend && level != 0) ? level : 0;
    endfunction

    task automatic push_bytes(input int start, input int n);
        for (int i = 0; i < n; i++) begin
            fifo_q.push_back(8'(start + i));
            pay_q.push_back(8'(start + i));
        end
    endtask

    task automatic expect_pkt(input int len);
        logic [7:0] b;
        exp_q.push_back('{8'hA5, 1'b0, 1'b0});
        exp_q.push_back('{8'(mseq), 1'b0, 1'b0});
        exp_q.push_back('{8'(len >> 8), 1'b0, 1'b0});
        exp_q.push_back('{8'(len), 1'b0, 1'b0});
        for (int i = 0; i < len; i++) begin
            b = pay_q.pop_front();
            exp_q.push_back('{b, i == len - 1, 1'b1});
        end
        mseq = (mseq + 1) % 256;
    endtask

    task automatic wait_exp(input int budget, input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick(1);
            n++;
        end
        chk(name, exp_q.size(), 0);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while (pkt_busy && n < budget) begin
            tick(1);
            n++;
        end
        chk(name, pkt_busy, 0);
    endtask

    task automatic cap_clear();
        cap_q.delete();
        capl_q.delete();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_tx_valid"}, tx_valid, 0);
        chk({tag, "_tx_data"}, tx_data, 0);
        chk({tag, "_tx_last"}, tx_last, 0);
        chk({tag, "_pkt_busy"}, pkt_busy, 0);
        chk({tag, "_pkt_cnt"}, pkt_cnt, 0);
        chk({tag, "_underrun"}, underrun_err, 0);
        chk({tag, "_rd_en"}, fifo_rd_en, 0);
    endtask

    // read-side FIFO: registered data/valid one cycle after rd_en, registered level
    always @(posedge sys_clk) begin
        if (fifo_rd_en) begin
            rd_total++;
            chk("fifo_underflow", fifo_q.size() != 0, 1);
            if (fifo_q.size() != 0) fifo_dout <= fifo_q.pop_front();
        end
        fifo_valid <= fifo_rd_en;
        fifo_level <= 15'(fifo_q.size());
        fifo_empty <= fifo_q.size() == 0 || force_empty;
    end

    initial forever begin
        @(posedge sys_clk);
        #1;
        tx_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge sys_clk) begin
        if (rst_n) begin
            chk("pkt_cnt", pkt_cnt, m_pkt);
            chk("last_without_valid", tx_last & ~tx_valid, 0);
            chk("skid_occupancy", (rd_total - pay_popped) <= 2, 1);
            if (gap_left > 0) begin
                chk("gap_idle", tx_valid, 0);
                gap_left--;
            end
            if (tx_valid && tx_ready) begin
                cap_q.push_back(tx_data);
                capl_q.push_back(tx_last);
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_byte: got %02h while no byte was due", tx_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("tx_data", tx_data, mon_e.d);
                    chk("tx_last", tx_last, mon_e.last);
                    if (mon_e.pay) pay_popped++;
                    if (mon_e.last) begin
                        m_pkt++;
                        gap_left = GAP_CYC;
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g, rd0, p0, n;
        rst_n = 1'b0;
        enable = 1'b0;
        frame_end = 1'b0;
        tx_ready = 1'b1;
        tick(3);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        enable = 1'b1;
        tick(2);

        // full packet, always ready
        cap_clear();
        rd0 = rd_total;
        push_bytes(8'h10, 8);
        expect_pkt(launch_len(pay_q.size(), 0));
        wait_exp(200, "t1_done");
        g = 0;
        while (pkt_busy && g < 100) begin
            g++;
            tick(1);
        end
        chk("t1_gap_len", g, GAP_CYC);
        chk("t1_count", cap_q.size(), 12);
        for (int i = 0; i < 12; i++) chk("t1_byte", cap_q[i], t1e[i]);
        chk("t1_last_flag", capl_q[11], 1);
        chk("t1_pkt_cnt", pkt_cnt, 1);
        chk("t1_reads", rd_total - rd0, 8);

        // frame_end on empty FIFO is consumed without launch; later tail flush
        cap_clear();
        frame_end = 1'b1;
        tick(1);
        frame_end = 1'b0;
        tick(3);
        push_bytes(8'h20, 3);
        tick(30);
        chk("t2_no_launch", pkt_busy, 0);
        chk("t2_no_bytes", cap_q.size(), 0);
        expect_pkt(launch_len(pay_q.size(), 1));
        frame_end = 1'b1;
        tick(1);
        frame_end = 1'b0;
        wait_exp(200, "t2_done");
        wait_idle(100, "t2_idle");
        tick(30);
        chk("t2_pend_cleared", cap_q.size(), 7);
        for (int i = 0; i < 7; i++) chk("t2_byte", cap_q[i], t2e[i]);
        chk("t2_last_flag", capl_q[6], 1);
        chk("t2_not_last", capl_q[5], 0);

        // random backpressure
        cap_clear();
        rand_rdy = 1'b1;
        rd0 = rd_total;
        push_bytes(8'h30, 8);
        expect_pkt(launch_len(pay_q.size(), 0));
        wait_exp(400, "t3_done");
        wait_idle(100, "t3_idle");
        rand_rdy = 1'b0;
        chk("t3_count", cap_q.size(), 12);
        chk("t3_first_payload", cap_q[4], 8'h30);
        chk("t3_last_payload", cap_q[11], 8'h37);
        chk("t3_reads", rd_total - rd0, 8);
        chk("t3_no_underrun", underrun_err, 0);

        // starvation mid-payload
        cap_clear();
        chk("t4_err_before", underrun_err, 0);
        rd0 = rd_total;
        push_bytes(8'h40, 8);
        expect_pkt(launch_len(pay_q.size(), 0));
        n = 0;
        while ((rd_total - rd0) < 2 && n < 100) begin
            tick(1);
            n++;
        end
        chk("t4_reads_started", (rd_total - rd0) >= 2, 1);
        force_empty = 1'b1;
        tick(STALL_MAX + 8);
        chk("t4_err_set", underrun_err, 1);
        chk("t4_still_busy", pkt_busy, 1);
        force_empty = 1'b0;
        wait_exp(200, "t4_done");
        wait_idle(100, "t4_idle");
        chk("t4_err_sticky", underrun_err, 1);
        chk("t4_count", cap_q.size(), 12);
        chk("t4_reads", rd_total - rd0, 8);

        // reset mid-payload
        cap_clear();
        p0 = pay_popped;
        push_bytes(8'h50, 8);
        expect_pkt(launch_len(pay_q.size(), 0));
        n = 0;
        while ((pay_popped - p0) < 2 && n < 100) begin
            tick(1);
            n++;
        end
        chk("t6_payload_started", (pay_popped - p0) >= 2, 1);
        rst_n = 1'b0;
        exp_q.delete();
        fifo_q.delete();
        pay_q.delete();
        mseq = 0;
        m_pkt = 0;
        gap_left = 0;
        rd_total = 0;
        pay_popped = 0;
        @(negedge sys_clk);
        chk_reset_outputs("t6_rst");
        tick(3);
        rst_n = 1'b1;
        tick(3);
        cap_clear();

        // 256 back-to-back packets, then seq wraps
        push_bytes(0, 256 * PKT_LEN);
        for (int k = 0; k < 256; k++) expect_pkt(launch_len(pay_q.size(), 0));
        wait_exp(30000, "t5_done");
        wait_idle(100, "t5_idle");
        chk("t5_pkt_cnt", pkt_cnt, 256);
        chk("t5_count", cap_q.size(), 256 * 12);
        chk("t5_first_seq", cap_q[1], 8'h00);
        chk("t5_mid_seq", cap_q[128 * 12 + 1], 8'h80);
        chk("t5_last_seq", cap_q[255 * 12 + 1], 8'hFF);
        chk("t5_err_cleared", underrun_err, 0);
        cap_clear();
        push_bytes(8'hE0, 8);
        expect_pkt(launch_len(pay_q.size(), 0));
        wait_exp(200, "t5_wrap_done");
        wait_idle(100, "t5_wrap_idle");
        chk("t5_wrap_seq", cap_q[1], 8'h00);
        chk("t5_wrap_payload", cap_q[4], 8'hE0);
        chk("t5_pkt_cnt_257", pkt_cnt, 257);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
